dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_array.sv | 28 ++
 rtl/dmem_responder.sv | 116 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// default parameters, word/lane geometry and the address-legality check.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_WAIT_CYCLES = 1;
  localparam int DEF_ADDR_W      = 6;
  localparam int WORD_W          = 32;
  localparam int LANES           = 4;
  localparam int LANE_W          = 8;

  // Word-aligned and inside the 2**aw word window.
  function automatic logic addr_err(input logic [WORD_W-1:0] a, input int aw);
    return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// 2**ADDR_W x 32 word store: synchronous per-byte write, asynchronous read.
// No reset; contents survive responder resets.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic [LANES-1:0]  wbe,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wbe[i]) begin
        mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding memory responder: accept in IDLE, WAIT_CYCLES wait states,
// one-cycle ack; latency WAIT_CYCLES+1, ready held low until the access retires.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [LANES-1:0]  be,
  output logic              ready,
  output logic              ack,
  output logic [WORD_W-1:0] rdata,
  output logic              err
);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              lat_we;
  logic [WORD_W-1:0] lat_addr, lat_wdata;
  logic [LANES-1:0]  lat_be;

  logic              accept;
  logic              cur_we, cur_err, lat_err;
  logic [WORD_W-1:0] cur_addr, cur_wdata;
  logic [LANES-1:0]  cur_be;
  logic [LANES-1:0]  mem_wbe;
  logic [WORD_W-1:0] mem_rdata;

  assign accept = req && (state == IDLE);

  // With zero wait states the commit edge is the acceptance edge itself,
  // so the write port must see the live request rather than the latch.
  always_comb begin
    cur_we    = lat_we;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    cur_be    = lat_be;
    if (state == IDLE) begin
      cur_we    = we;
      cur_addr  = addr;
      cur_wdata = wdata;
      cur_be    = be;
    end
  end

  assign cur_err = addr_err(cur_addr, ADDR_W);
  assign lat_err = addr_err(lat_addr, ADDR_W);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_we    <= we;
        lat_addr  <= addr;
        lat_wdata <= wdata;
        lat_be    <= be;
      end
    end
  end

  // Commit on the edge entering RESP; a reset on that edge aborts the store.
  assign mem_wbe = (!reset && state != RESP && state_nxt == RESP && cur_we && !cur_err)
                   ? cur_be : '0;

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .wbe   (mem_wbe),
    .waddr (cur_addr[ADDR_W+1:2]),
    .wdata (cur_wdata),
    .raddr (lat_addr[ADDR_W+1:2]),
    .rdata (mem_rdata)
  );

  assign ready = (state == IDLE);
  assign ack   = (state == RESP);
  assign err   = ack && lat_err;
  assign rdata = (ack && !lat_we && !lat_err) ? mem_rdata : '0;

endmodule
